// File: rtl/serial_rx_ctrl_pkg.sv
// Shared register map, bit positions and status layout for the serial receive controller.
package serial_rx_ctrl_pkg;

  localparam int unsigned REG_W = 8;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_CNT  = 2'd3;

  localparam int unsigned STAT_NE   = 0;
  localparam int unsigned STAT_FULL = 1;
  localparam int unsigned STAT_OVR  = 2;
  localparam int unsigned STAT_ERR  = 3;

  localparam int unsigned CTRL_RX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned CNT_FLUSH = 7;

  // STATUS register image, MSB first
  typedef struct packed {
    logic [3:0] rsvd;
    logic       err;
    logic       ovr;
    logic       full;
    logic       ne;
  } stat_t;

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module serial_rx_fifo
  import serial_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout_c,
  output logic              o_full_c,
  output logic              o_empty_c,
  output logic [CNT_W-1:0]  o_count,
  output logic [CNT_W-1:0]  o_count_nxt_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;
  logic              w_push;

  assign o_full_c      = (r_count == CNT_W'(DEPTH));
  assign o_empty_c     = (r_count == '0);
  assign o_dout_c      = r_mem[r_rptr];
  assign o_count       = r_count;
  assign w_pop         = i_pop & ~o_empty_c;
  assign w_push        = i_push & (~o_full_c | w_pop);
  assign o_count_nxt_c = i_flush ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));

  // Pointer and occupancy tracking; flush wins over any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= o_count_nxt_c;
    end
  end

  // Storage array, written only by accepted pushes
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// Serial receive front end: frame/error edge events, byte FIFO, 4-register bus interface and irq.
module serial_rx_ctrl
  import serial_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  input  logic              cs,
  input  logic [1:0]        addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              irq
);

  logic              r_valid_d;
  logic              r_error_d;
  logic              r_init;
  logic              r_rx_en;
  logic              r_irq_en;
  logic              r_ovr;
  logic              r_err;

  logic              w_rd;
  logic              w_wr;
  logic              w_push_evt;
  logic              w_err_evt;
  logic              w_pop;
  logic              w_flush;
  logic              w_stat_wr;
  logic              w_ctrl_wr;
  logic              w_ovr_nxt;
  logic              w_err_nxt;
  logic              w_rx_en_nxt;
  logic              w_irq_en_nxt;
  logic              w_irq_nxt;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_dout;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [7:0]        w_rd_val;
  stat_t             w_stat;
  logic              w_unused;

  assign w_rd = cs & rd;
  assign w_wr = cs & wr;

  // r_init masks the first cycle after reset so a level already high at release is not an edge
  assign w_push_evt = rx_valid & ~r_valid_d & r_rx_en & ~r_init;
  assign w_err_evt  = rx_error & ~r_error_d & r_rx_en & ~r_init;

  assign w_pop     = w_rd & (addr == ADDR_DATA);
  assign w_flush   = w_wr & (addr == ADDR_CNT) & wdata[CNT_FLUSH];
  assign w_stat_wr = w_wr & (addr == ADDR_STAT);
  assign w_ctrl_wr = w_wr & (addr == ADDR_CTRL);

  // Set beats a same-cycle write-1-to-clear
  assign w_ovr_nxt = (w_push_evt & w_full & ~w_pop) | (r_ovr & ~(w_stat_wr & wdata[STAT_OVR]));
  assign w_err_nxt = w_err_evt | (r_err & ~(w_stat_wr & wdata[STAT_ERR]));

  assign w_rx_en_nxt  = w_ctrl_wr ? wdata[CTRL_RX_EN]  : r_rx_en;
  assign w_irq_en_nxt = w_ctrl_wr ? wdata[CTRL_IRQ_EN] : r_irq_en;
  assign w_irq_nxt    = w_irq_en_nxt & ((w_count_nxt != '0) | w_ovr_nxt | w_err_nxt);

  assign w_stat   = '{rsvd: 4'b0, err: r_err, ovr: r_ovr, full: w_full, ne: ~w_empty};
  assign w_unused = &{1'b0, wdata[6:4]};

  serial_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push_evt),
    .i_pop         (w_pop),
    .i_flush       (w_flush),
    .i_din         (rx_data),
    .o_dout_c      (w_dout),
    .o_full_c      (w_full),
    .o_empty_c     (w_empty),
    .o_count       (w_count),
    .o_count_nxt_c (w_count_nxt)
  );

  // Read mux over pre-write register values
  always_comb begin
    w_rd_val = '0;
    case (addr)
      ADDR_DATA: w_rd_val = w_empty ? 8'h00 : 8'(w_dout);
      ADDR_STAT: w_rd_val = w_stat;
      ADDR_CTRL: w_rd_val = {6'b0, r_irq_en, r_rx_en};
      ADDR_CNT:  w_rd_val = 8'(w_count);
      default:   w_rd_val = '0;
    endcase
  end

  // Edge-detect delays, control, sticky flags, read data and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_d <= 1'b0;
      r_error_d <= 1'b0;
      r_init    <= 1'b1;
      r_rx_en   <= 1'b1;
      r_irq_en  <= 1'b0;
      r_ovr     <= 1'b0;
      r_err     <= 1'b0;
      rdata     <= '0;
      irq       <= 1'b0;
    end else begin
      r_valid_d <= rx_valid;
      r_error_d <= rx_error;
      r_init    <= 1'b0;
      r_rx_en   <= w_rx_en_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_ovr     <= w_ovr_nxt;
      r_err     <= w_err_nxt;
      irq       <= w_irq_nxt;
      if (w_rd) rdata <= w_rd_val;
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed self-checking bench for serial_rx_ctrl: vector table plus hand-timed corner sequences.
module tb_serial_rx_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       cs;
  logic [1:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int K_FRAME = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;

  typedef struct {
    int         kind;
    logic [1:0] a;
    logic [7:0] dat;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  serial_rx_ctrl #(.DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .cs       (cs),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // All tasks start and end on a negedge
  task automatic frame(input logic [7:0] d, input int hold);
    rx_data  = d;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    v = rdata;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; wdata = 8'h00;
  endtask

  task automatic add(input int k, input logic [1:0] a, input logic [7:0] d, input int h, input logic [7:0] e);
    vec_t v;
    v.kind = k; v.a = a; v.dat = d; v.hold = h; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] v;

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    cs = 1'b0; addr = 2'd0; rd = 1'b0; wr = 1'b0; wdata = 8'h00;

    // Single long frame
    add(K_FRAME, 2'd0, 8'h41, 5, 8'h00);
    add(K_READ,  2'd3, 8'h00, 0, 8'h01);
    add(K_READ,  2'd1, 8'h00, 0, 8'h01);
    add(K_READ,  2'd0, 8'h00, 0, 8'h41);
    add(K_READ,  2'd1, 8'h00, 0, 8'h00);
    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) add(K_FRAME, 2'd0, 8'(i), 1, 8'h00);
    add(K_READ, 2'd1, 8'h00, 0, 8'h07);
    for (int i = 0; i < 16; i++) add(K_READ, 2'd0, 8'h00, 0, 8'(i));
    add(K_READ,  2'd0, 8'h00, 0, 8'h00);
    add(K_READ,  2'd3, 8'h00, 0, 8'h00);
    add(K_READ,  2'd1, 8'h00, 0, 8'h04);
    add(K_WRITE, 2'd1, 8'h04, 0, 8'h00);
    add(K_READ,  2'd1, 8'h00, 0, 8'h00);
    // Flush with three queued bytes
    for (int i = 0; i < 3; i++) add(K_FRAME, 2'd0, 8'(8'hC0 + i), 1, 8'h00);
    add(K_READ,  2'd3, 8'h00, 0, 8'h03);
    add(K_WRITE, 2'd3, 8'h80, 0, 8'h00);
    add(K_READ,  2'd3, 8'h00, 0, 8'h00);
    add(K_READ,  2'd1, 8'h00, 0, 8'h00);
    // Receive disabled, then DATA writes ignored
    add(K_WRITE, 2'd2, 8'h00, 0, 8'h00);
    add(K_READ,  2'd2, 8'h00, 0, 8'h00);
    add(K_FRAME, 2'd0, 8'h33, 2, 8'h00);
    add(K_READ,  2'd3, 8'h00, 0, 8'h00);
    add(K_READ,  2'd1, 8'h00, 0, 8'h00);
    add(K_WRITE, 2'd2, 8'h01, 0, 8'h00);
    add(K_READ,  2'd2, 8'h00, 0, 8'h01);
    add(K_WRITE, 2'd0, 8'h5A, 0, 8'h00);
    add(K_READ,  2'd3, 8'h00, 0, 8'h00);

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    bus_read(2'd2, v); check("reset_ctrl", v, 8'h01);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_FRAME: frame(vecs[i].dat, vecs[i].hold);
        K_WRITE: bus_write(vecs[i].a, vecs[i].dat);
        default: begin
          bus_read(vecs[i].a, v);
          check($sformatf("vec%0d_rd_a%0d", i, vecs[i].a), v, vecs[i].exp);
        end
      endcase
    end

    // Error event with a frame: flag sets, byte still queued, W1C clears ERR only
    rx_error = 1'b1;
    frame(8'h55, 1);
    bus_read(2'd1, v); check("err_stat", v, 8'h09);
    bus_write(2'd1, 8'h08);
    bus_read(2'd1, v); check("err_clr_stat", v, 8'h01);
    bus_read(2'd0, v); check("err_data", v, 8'h55);
    rx_error = 1'b0;
    @(negedge clk);

    // Full FIFO with a same-cycle pop and push
    for (int i = 0; i < 16; i++) frame(8'(8'h10 + i), 1);
    bus_read(2'd1, v); check("full_stat", v, 8'h03);
    rx_data = 8'hAA; rx_valid = 1'b1; cs = 1'b1; rd = 1'b1; addr = 2'd0;
    @(posedge clk); #1;
    check("pushpop_rdata", rdata, 8'h10);
    @(negedge clk);
    rx_valid = 1'b0; cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    bus_read(2'd3, v); check("pushpop_cnt", v, 8'h10);
    bus_read(2'd1, v); check("pushpop_stat", v, 8'h03);
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, v);
      check($sformatf("drain%0d", i), v, (i == 15) ? 8'hAA : 8'(8'h11 + i));
    end

    // Interrupt timing
    bus_write(2'd2, 8'h03);
    check("irq_idle", {7'b0, irq}, 8'h00);
    rx_data = 8'h77; rx_valid = 1'b1;
    @(posedge clk); #1;
    check("irq_after_push", {7'b0, irq}, 8'h01);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = 2'd0;
    @(posedge clk); #1;
    check("irq_pop_rdata", rdata, 8'h77);
    check("irq_after_pop", {7'b0, irq}, 8'h00);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    bus_write(2'd2, 8'h01);
    rx_data = 8'h66; rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("irq_masked%0d", i), {7'b0, irq}, 8'h00);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    bus_read(2'd0, v); check("masked_data", v, 8'h66);

    // Reset with rx_valid high
    frame(8'h12, 1);
    bus_write(2'd2, 8'h03);
    rx_data = 8'h34; rx_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst2_rdata", rdata, 8'h00);
    check("rst2_irq", {7'b0, irq}, 8'h00);
    repeat (3) @(negedge clk);
    bus_read(2'd3, v); check("rst2_cnt", v, 8'h00);
    bus_read(2'd2, v); check("rst2_ctrl", v, 8'h01);
    bus_read(2'd1, v); check("rst2_stat", v, 8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    frame(8'h99, 1);
    bus_read(2'd3, v); check("rst2_cnt_after", v, 8'h01);
    bus_read(2'd0, v); check("rst2_data_after", v, 8'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
